// File: rtl/exception_unit.sv
// Exception/interrupt sequencer: owns ELR/ESR, selects the fetch PC source and
// runs the level-sensitive external request handshake.
module exception_unit #(
   parameter int unsigned   N          = 64,
   parameter logic [N-1:0]  EXC_VECTOR = N'(64'h00000000000000D8),
   parameter logic [3:0]    EXT_CODE   = 4'b0001
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] PC,
   input  logic         Exc,
   input  logic [3:0]   EStatus,
   input  logic         ERet,
   input  logic         ExtlRQ,
   output logic [1:0]   PCSel,
   output logic [N-1:0] ExcVector,
   output logic [N-1:0] ELR,
   output logic [3:0]   ESR,
   output logic         ExcAck,
   output logic         ExtlAck,
   output logic         InHandler,
   output logic         NestedErr
);

   localparam int unsigned SEL_W = 2;
   localparam logic [SEL_W-1:0] SEL_SEQ = SEL_W'(0);
   localparam logic [SEL_W-1:0] SEL_VEC = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_ELR = SEL_W'(2);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_HANDLER = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [N-1:0]       elr_q, elr_d;
   logic [3:0]         esr_q, esr_d;
   logic               extl_ack_q, extl_ack_d;
   logic               nested_q, nested_d;
   logic               req_armed_q, req_armed_d;
   logic [SEL_W-1:0]   pcsel_c;
   logic               exc_ack_c;

   // Next-state and Mealy redirect logic.
   always_comb begin
      state_d     = state_q;
      elr_d       = elr_q;
      esr_d       = esr_q;
      extl_ack_d  = extl_ack_q;
      nested_d    = nested_q;
      req_armed_d = req_armed_q;
      pcsel_c     = SEL_SEQ;
      exc_ack_c   = 1'b0;

      // Handshake release happens regardless of state.
      if (!ExtlRQ) begin
         extl_ack_d  = 1'b0;
         req_armed_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (Exc) begin
               pcsel_c   = SEL_VEC;
               exc_ack_c = 1'b1;
               elr_d     = PC;
               esr_d     = EStatus;
               state_d   = ST_HANDLER;
            end else if (ExtlRQ && !extl_ack_q && req_armed_q) begin
               pcsel_c     = SEL_VEC;
               exc_ack_c   = 1'b1;
               elr_d       = PC;
               esr_d       = EXT_CODE;
               extl_ack_d  = 1'b1;
               req_armed_d = 1'b0;
               state_d     = ST_HANDLER;
            end
         end
         ST_HANDLER: begin
            if (ERet) begin
               pcsel_c = SEL_ELR;
               state_d = ST_IDLE;
            end else if (Exc) begin
               nested_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Redirect outputs are forced quiet while reset is asserted.
      if (!reset) begin
         pcsel_c   = SEL_SEQ;
         exc_ack_c = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         elr_q       <= '0;
         esr_q       <= '0;
         extl_ack_q  <= 1'b0;
         nested_q    <= 1'b0;
         req_armed_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         elr_q       <= elr_d;
         esr_q       <= esr_d;
         extl_ack_q  <= extl_ack_d;
         nested_q    <= nested_d;
         req_armed_q <= req_armed_d;
      end
   end

   assign PCSel     = pcsel_c;
   assign ExcAck    = exc_ack_c;
   assign ExcVector = EXC_VECTOR;
   assign ELR       = elr_q;
   assign ESR       = esr_q;
   assign ExtlAck   = extl_ack_q;
   assign NestedErr = nested_q;
   assign InHandler = (state_q == ST_HANDLER);

endmodule

// File: tb/tb_exception_unit.sv
// Directed vector bench for exception_unit: table of per-cycle stimulus with
// expected outputs, plus an asynchronous mid-handler reset sequence.
module tb_exception_unit;

   logic        clk;
   logic        reset;
   logic [63:0] PC;
   logic        Exc;
   logic [3:0]  EStatus;
   logic        ERet;
   logic        ExtlRQ;
   logic [1:0]  PCSel;
   logic [63:0] ExcVector;
   logic [63:0] ELR;
   logic [3:0]  ESR;
   logic        ExcAck;
   logic        ExtlAck;
   logic        InHandler;
   logic        NestedErr;

   int n_cmp = 0;
   int n_bad = 0;

   exception_unit dut (
      .clk(clk), .reset(reset), .PC(PC), .Exc(Exc), .EStatus(EStatus),
      .ERet(ERet), .ExtlRQ(ExtlRQ), .PCSel(PCSel), .ExcVector(ExcVector),
      .ELR(ELR), .ESR(ESR), .ExcAck(ExcAck), .ExtlAck(ExtlAck),
      .InHandler(InHandler), .NestedErr(NestedErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic        exc;
      logic [3:0]  es;
      logic        eret;
      logic        rq;
      logic [1:0]  pcsel;
      logic        ack;
      logic [63:0] elr;
      logic [3:0]  esr;
      logic        xack;
      logic        inh;
      logic        nest;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [63:0] pc, logic exc, logic [3:0] es, logic eret,
                               logic rq, logic [1:0] pcsel, logic ack, logic [63:0] elr,
                               logic [3:0] esr, logic xack, logic inh, logic nest);
      vec_t v;
      v.pc = pc; v.exc = exc; v.es = es; v.eret = eret; v.rq = rq;
      v.pcsel = pcsel; v.ack = ack; v.elr = elr; v.esr = esr;
      v.xack = xack; v.inh = inh; v.nest = nest;
      return v;
   endfunction

   task automatic check(string name, int step, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
      end
   endtask

   task automatic check_all(int step, vec_t v);
      check("PCSel",     step, 64'(PCSel),     64'(v.pcsel));
      check("ExcAck",    step, 64'(ExcAck),    64'(v.ack));
      check("ELR",       step, ELR,            v.elr);
      check("ESR",       step, 64'(ESR),       64'(v.esr));
      check("ExtlAck",   step, 64'(ExtlAck),   64'(v.xack));
      check("InHandler", step, 64'(InHandler), 64'(v.inh));
      check("NestedErr", step, 64'(NestedErr), 64'(v.nest));
   endtask

   initial begin
      //           pc       exc es  er rq  sel ack elr      esr xa ih ne
      vecs.push_back(mk(64'h0,   0, 4'h0, 0, 0, 2'd0, 0, 64'h0,   4'h0, 0, 0, 0)); // 0 reset state
      vecs.push_back(mk(64'h40,  1, 4'h2, 0, 0, 2'd1, 0, 64'h0,   4'h0, 0, 0, 0)); // 1 sync exc
      vecs.push_back(mk(64'hD8,  0, 4'h0, 0, 0, 2'd0, 0, 64'h40,  4'h2, 0, 1, 0)); // 2
      vecs.push_back(mk(64'hDC,  0, 4'h0, 1, 0, 2'd2, 0, 64'h40,  4'h2, 0, 1, 0)); // 3 eret
      vecs.push_back(mk(64'h44,  0, 4'h0, 0, 0, 2'd0, 0, 64'h40,  4'h2, 0, 0, 0)); // 4
      vecs.push_back(mk(64'h100, 0, 4'h0, 0, 1, 2'd1, 0, 64'h40,  4'h2, 0, 0, 0)); // 5 ext req
      vecs.push_back(mk(64'hD8,  0, 4'h0, 0, 1, 2'd0, 0, 64'h100, 4'h1, 1, 1, 0)); // 6
      vecs.push_back(mk(64'hDC,  0, 4'h0, 1, 1, 2'd2, 0, 64'h100, 4'h1, 1, 1, 0)); // 7 eret, rq held
      vecs.push_back(mk(64'h100, 0, 4'h0, 0, 1, 2'd0, 0, 64'h100, 4'h1, 1, 0, 0)); // 8 no re-entry
      vecs.push_back(mk(64'h104, 0, 4'h0, 0, 1, 2'd0, 0, 64'h100, 4'h1, 1, 0, 0)); // 9
      vecs.push_back(mk(64'h108, 0, 4'h0, 0, 0, 2'd0, 0, 64'h100, 4'h1, 1, 0, 0)); // 10 drop rq
      vecs.push_back(mk(64'h10C, 0, 4'h0, 0, 1, 2'd1, 0, 64'h100, 4'h1, 0, 0, 0)); // 11 re-raise
      vecs.push_back(mk(64'hD8,  0, 4'h0, 1, 0, 2'd2, 0, 64'h10C, 4'h1, 1, 1, 0)); // 12
      vecs.push_back(mk(64'h10C, 0, 4'h0, 0, 0, 2'd0, 0, 64'h10C, 4'h1, 0, 0, 0)); // 13
      vecs.push_back(mk(64'h200, 1, 4'h4, 0, 1, 2'd1, 0, 64'h10C, 4'h1, 0, 0, 0)); // 14 exc+rq
      vecs.push_back(mk(64'hD8,  0, 4'h0, 1, 1, 2'd2, 0, 64'h200, 4'h4, 0, 1, 0)); // 15 eret beats rq
      vecs.push_back(mk(64'h204, 0, 4'h0, 0, 1, 2'd1, 0, 64'h200, 4'h4, 0, 0, 0)); // 16 pending rq
      vecs.push_back(mk(64'hD8,  0, 4'h0, 0, 0, 2'd0, 0, 64'h204, 4'h1, 1, 1, 0)); // 17
      vecs.push_back(mk(64'h300, 1, 4'h7, 0, 0, 2'd0, 0, 64'h204, 4'h1, 0, 1, 0)); // 18 nested exc
      vecs.push_back(mk(64'h304, 0, 4'h0, 0, 0, 2'd0, 0, 64'h204, 4'h1, 0, 1, 1)); // 19
      vecs.push_back(mk(64'h308, 1, 4'h3, 1, 0, 2'd2, 0, 64'h204, 4'h1, 0, 1, 1)); // 20 eret beats exc
      vecs.push_back(mk(64'h208, 0, 4'h0, 0, 0, 2'd0, 0, 64'h204, 4'h1, 0, 0, 1)); // 21
      vecs.push_back(mk(64'h20C, 0, 4'h0, 1, 0, 2'd0, 0, 64'h204, 4'h1, 0, 0, 1)); // 22 eret in idle
      vecs.push_back(mk(64'h210, 0, 4'h0, 0, 0, 2'd0, 0, 64'h204, 4'h1, 0, 0, 1)); // 23
      // ExcAck mirrors the PCSel=01 redirect in this design
      foreach (vecs[i]) vecs[i].ack = (vecs[i].pcsel == 2'd1);

      reset = 1'b0; PC = '0; Exc = 1'b0; EStatus = '0; ERet = 1'b0; ExtlRQ = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         PC = vecs[i].pc; Exc = vecs[i].exc; EStatus = vecs[i].es;
         ERet = vecs[i].eret; ExtlRQ = vecs[i].rq;
         #1;
         check_all(i, vecs[i]);
         @(negedge clk);
      end
      check("ExcVector", 99, ExcVector, 64'hD8);

      // Asynchronous reset mid-handler with the external handshake active.
      PC = 64'h500; Exc = 1'b0; ERet = 1'b0; ExtlRQ = 1'b1;
      #1;
      check("acc_PCSel", 100, 64'(PCSel), 64'd1);
      @(negedge clk);
      #1;
      check("pre_InHandler", 101, 64'(InHandler), 64'd1);
      check("pre_ExtlAck",   101, 64'(ExtlAck),   64'd1);
      check("pre_ELR",       101, ELR,            64'h500);
      ERet = 1'b1;
      #1;
      check("pre_PCSel",     101, 64'(PCSel),     64'd2);
      #1 reset = 1'b0;
      #1;
      check("rst_InHandler", 102, 64'(InHandler), 64'd0);
      check("rst_ExtlAck",   102, 64'(ExtlAck),   64'd0);
      check("rst_ELR",       102, ELR,            64'h0);
      check("rst_ESR",       102, 64'(ESR),       64'h0);
      check("rst_NestedErr", 102, 64'(NestedErr), 64'd0);
      check("rst_PCSel",     102, 64'(PCSel),     64'd0);
      check("rst_ExcAck",    102, 64'(ExcAck),    64'd0);
      @(negedge clk);
      ERet = 1'b0;
      reset = 1'b1;
      #1;
      check("post_PCSel",    103, 64'(PCSel),     64'd1);
      check("post_ExcAck",   103, 64'(ExcAck),    64'd1);
      @(negedge clk);
      #1;
      check("post_ESR",      104, 64'(ESR),       64'h1);
      check("post_ExtlAck",  104, 64'(ExtlAck),   64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Sequential exception/interrupt sequencer placed directly downstream of the main controller.
- Consumes the controller's Exc, EStatus and ERet outputs and the external ExtlRQ request line.
- Holds the exception link register (ELR) and exception syndrome register (ESR).
- Drives the fetch-stage PC mux select and returns the ExcAck/ExtlAck handshakes to the controller and the external requester.

Parameters:
N, 64, datapath/PC width in bits
EXC_VECTOR, 64'h00000000000000D8, handler entry address (width N)
EXT_CODE, 4'b0001, ESR code written for an accepted external request

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
PC  input  N  address of the instruction currently executing
Exc  input  1  controller: current instruction raises a synchronous exception
EStatus  input  4  controller: syndrome code qualifying Exc
ERet  input  1  controller: current instruction is ERET
ExtlRQ  input  1  external interrupt request, level, 4-phase handshake
PCSel  output  2  00 = PC+4/branch, 01 = EXC_VECTOR, 10 = ELR
ExcVector  output  N  constant EXC_VECTOR
ELR  output  N  exception link register
ESR  output  4  exception syndrome register
ExcAck  output  1  one-cycle pulse to controller: exception taken this cycle
ExtlAck  output  1  external handshake acknowledge
InHandler  output  1  1 while state = HANDLER
NestedErr  output  1  sticky: an exception was raised inside the handler

Behaviour:
- State register: IDLE and HANDLER. State, ELR, ESR, ExtlAck and NestedErr are flops. PCSel and ExcAck are combinational (Mealy) from state and inputs; the redirect applies in the same cycle.
- Reset (reset = 0, asynchronous):
  - state = IDLE; ELR = 0; ESR = 0; ExtlAck = 0; NestedErr = 0.
  - Combinational outputs fall to PCSel = 00 and ExcAck = 0.
  - A reset taken mid-handler abandons the handler with no return.
- IDLE, Exc = 1 (highest priority):
  - PCSel = 01, ExcAck = 1.
  - On the edge: ELR <= PC, ESR <= EStatus, state <= HANDLER.
  - A concurrent ExtlRQ is not accepted and stays pending.
- IDLE, Exc = 0, ExtlRQ = 1, ExtlAck = 0, reqArmed = 1:
  - PCSel = 01, ExcAck = 1.
  - On the edge: ELR <= PC, so the interrupted instruction re-executes after ERET. Also ESR <= EXT_CODE, ExtlAck <= 1, state <= HANDLER.
- ExtlAck handshake:
  - ExtlAck stays 1 until ExtlRQ is sampled 0, then ExtlAck <= 0 on that edge, independent of state.
  - Internal flag reqArmed clears when an ExtlRQ is accepted and sets once ExtlRQ is sampled 0.
  - A request held high across an ERET is therefore never accepted twice.
- IDLE, ERet = 1: ignored. PCSel = 00, no state change.
- HANDLER, ERet = 1:
  - PCSel = 10 (target = ELR); on the edge state <= IDLE.
  - ELR and ESR keep their values.
  - ERet wins over a simultaneous Exc or ExtlRQ; NestedErr is not set.
- HANDLER, Exc = 1, ERet = 0:
  - No redirect (PCSel = 00, ExcAck = 0); ELR and ESR unchanged.
  - NestedErr <= 1, cleared only by reset.
- HANDLER, ExtlRQ: ignored until return to IDLE; serviced at the first IDLE cycle with the handshake conditions met.
- Defaults: PCSel = 00 and ExcAck = 0 whenever no rule above fires.
- InHandler = (state == HANDLER). ExcVector = EXC_VECTOR.
- No arithmetic; PC is captured verbatim at full N bits.

Test Plan:
- Release reset with all inputs 0 -> PCSel = 00, ELR = 0, ESR = 0, ExtlAck = 0, InHandler = 0.
- IDLE, PC = 0x40, Exc = 1, EStatus = 4'b0010 -> same cycle PCSel = 01, ExcAck = 1. Next cycle ELR = 0x40, ESR = 0x2, InHandler = 1. Then ERet = 1 -> PCSel = 10 and ELR = 0x40; next cycle InHandler = 0.
- ExtlRQ = 1 at PC = 0x100 -> ELR = 0x100, ESR = 4'b0001, ExtlAck = 1. Hold ExtlRQ through ERET -> no re-entry and InHandler stays 0. Drop ExtlRQ -> ExtlAck = 0 on the next edge. Raise ExtlRQ again -> accepted.
- Exc = 1 and ExtlRQ = 1 in the same IDLE cycle, EStatus = 4'b0100 -> ESR = 0x4 and ExtlAck stays 0. After ERET the request is taken: ESR = 0x1, ExtlAck = 1.
- Exc = 1 inside HANDLER -> PCSel = 00, ELR/ESR unchanged, NestedErr = 1 and it persists after ERET. ERet = 1 in IDLE -> PCSel = 00, no state change.
- reset pulled low asynchronously mid-clock while InHandler = 1 and ExtlAck = 1 -> all registers clear immediately with no clock edge, and PCSel = 00.
